// File: rtl/instr_prefetch_queue.sv
// Instruction fetch stage: sequential ROM fetch into a small FIFO feeding Control_unit
// through a valid/ready handshake. A taken jump flushes the queue and refetches.
module instr_prefetch_queue #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
)(
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       i_Jump,
  input  logic [ADDR_W-1:0]          i_Jump_Addr,
  output logic [ADDR_W-1:0]          o_Mem_Addr,
  output logic                       o_Mem_Req,
  input  logic [DATA_W-1:0]          i_Mem_Data,
  output logic [DATA_W-1:0]          o_Instruction,
  output logic [ADDR_W-1:0]          o_Instr_Addr,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [$clog2(DEPTH):0]     o_Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] fetch_pc, req_addr;
  logic              inflight;
  logic [CW:0]       credit;
  logic              issue, push, pop, valid;

  // Outstanding return already owns a slot, so occupancy plus inflight is the credit.
  // A same-cycle pop is deliberately not counted.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue  = !Rst && !i_Jump && (credit < (CW+1)'(DEPTH));
  assign push   = inflight && !i_Jump;
  assign valid  = !Rst && (count != '0);
  assign pop    = valid && i_Ready && !i_Jump;

  assign o_Mem_Req     = issue;
  assign o_Mem_Addr    = Rst ? '0 : fetch_pc;
  assign o_Valid       = valid;
  assign o_Instruction = valid ? data_q[rd_ptr] : '0;
  assign o_Instr_Addr  = valid ? addr_q[rd_ptr] : '0;
  assign o_Count       = Rst ? '0 : count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_pc <= '0;
      req_addr <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (i_Jump) begin
      // Flush: the pending return is dropped by clearing inflight.
      fetch_pc <= i_Jump_Addr;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_addr <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      data_q[wr_ptr] <= i_Mem_Data;
      addr_q[wr_ptr] <= req_addr;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed + random bench for instr_prefetch_queue; a queue of expected fetch addresses
// is rebuilt on every reset/jump and consumed on every accepted instruction.
module tb_instr_prefetch_queue;
  logic       Clk, Rst, i_Jump, i_Ready, o_Mem_Req, o_Valid;
  logic [7:0] i_Jump_Addr, o_Mem_Addr, o_Instr_Addr;
  logic [8:0] i_Mem_Data, o_Instruction;
  logic [2:0] o_Count;

  int passed = 0, total = 0, accepted = 0;
  logic [7:0] exp_q[$];

  instr_prefetch_queue #(.DATA_W(9), .ADDR_W(8), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .i_Jump(i_Jump), .i_Jump_Addr(i_Jump_Addr),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Req(o_Mem_Req), .i_Mem_Data(i_Mem_Data),
    .o_Instruction(o_Instruction), .o_Instr_Addr(o_Instr_Addr), .o_Valid(o_Valid),
    .i_Ready(i_Ready), .o_Count(o_Count)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [8:0] rom(input logic [7:0] a);
    return {a[2:0], a[5:0]};
  endfunction

  // One-cycle-latency ROM; idle cycles return a poison word.
  always @(posedge Clk) i_Mem_Data <= o_Mem_Req ? rom(o_Mem_Addr) : 9'h1FF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic refill(input logic [7:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + 8'(i));
  endtask

  task automatic mon();
    logic [7:0] e;
    if (Rst) refill(8'h00);
    else if (i_Jump) refill(i_Jump_Addr);
    else if (o_Valid && i_Ready) begin
      if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_addr", o_Instr_Addr, e);
        chk("sb_data", o_Instruction, rom(e));
        accepted++;
      end
    end
  endtask

  task automatic half(); @(negedge Clk); mon(); endtask
  task automatic fin();  @(posedge Clk); #1; endtask
  task automatic cyc();  half(); fin(); endtask

  initial begin
    Rst = 1; i_Jump = 0; i_Jump_Addr = 0; i_Ready = 1;
    fin();
    // reset state
    half();
    chk("rst_valid", o_Valid, 0);
    chk("rst_req", o_Mem_Req, 0);
    chk("rst_maddr", o_Mem_Addr, 0);
    chk("rst_count", o_Count, 0);
    fin();
    fin();

    // latency from reset release and gap-free streaming
    Rst = 0;
    half(); chk("c1_req", o_Mem_Req, 1); chk("c1_addr", o_Mem_Addr, 0); chk("c1_valid", o_Valid, 0); fin();
    half(); chk("c2_valid", o_Valid, 0); chk("c2_addr", o_Mem_Addr, 1); fin();
    half(); chk("c3_valid", o_Valid, 1); chk("c3_iaddr", o_Instr_Addr, 0); chk("c3_instr", o_Instruction, rom(0)); fin();
    for (int i = 0; i < 10; i++) begin half(); chk("stream_valid", o_Valid, 1); fin(); end

    // back-pressure saturation then drain
    Rst = 1; cyc(); Rst = 0; i_Ready = 0;
    for (int i = 0; i < 8; i++) cyc();
    half(); chk("full_count", o_Count, 4); chk("full_req", o_Mem_Req, 0); chk("full_head", o_Instr_Addr, 0); fin();
    i_Ready = 1;
    for (int i = 0; i < 8; i++) begin half(); chk("drain_valid", o_Valid, 1); fin(); end

    // jump with 3 queued and one return in flight
    Rst = 1; cyc(); Rst = 0; i_Ready = 0;
    for (int i = 0; i < 4; i++) cyc();
    i_Jump = 1; i_Jump_Addr = 8'h40;
    half(); chk("pre_jump_count", o_Count, 3); chk("jump_noreq", o_Mem_Req, 0); fin();
    i_Jump = 0; i_Ready = 1;
    half(); chk("j1_count", o_Count, 0); chk("j1_valid", o_Valid, 0);
    chk("j1_maddr", o_Mem_Addr, 8'h40); chk("j1_req", o_Mem_Req, 1); fin();
    half(); chk("j2_valid", o_Valid, 0); fin();
    half(); chk("j3_valid", o_Valid, 1); chk("j3_iaddr", o_Instr_Addr, 8'h40); fin();
    for (int i = 0; i < 3; i++) cyc();

    // address wrap
    i_Jump = 1; i_Jump_Addr = 8'hFE; cyc(); i_Jump = 0;
    cyc(); cyc();
    half(); chk("wrap_first", o_Instr_Addr, 8'hFE); fin();
    for (int i = 0; i < 3; i++) begin
      half(); chk("wrap_addr", o_Instr_Addr, 8'(8'hFF + i)); fin();
    end

    // reset mid-stream with a full queue
    i_Ready = 0;
    for (int i = 0; i < 6; i++) cyc();
    half(); chk("mid_full", o_Count, 4); fin();
    Rst = 1;
    half();
    chk("mr_valid", o_Valid, 0); chk("mr_req", o_Mem_Req, 0); chk("mr_maddr", o_Mem_Addr, 0);
    chk("mr_instr", o_Instruction, 0); chk("mr_iaddr", o_Instr_Addr, 0); chk("mr_count", o_Count, 0);
    fin();
    Rst = 0; i_Ready = 1;
    half(); chk("mr1_req", o_Mem_Req, 1); chk("mr1_addr", o_Mem_Addr, 0); fin();
    cyc();
    half(); chk("mr3_valid", o_Valid, 1); chk("mr3_iaddr", o_Instr_Addr, 0); fin();

    // random ready / jumps
    accepted = 0;
    for (int i = 0; i < 500; i++) begin
      i_Jump      = ($urandom_range(0, 19) == 0);
      i_Jump_Addr = 8'($urandom);
      i_Ready     = 1'($urandom_range(0, 1));
      cyc();
    end
    i_Jump = 0; i_Ready = 0;
    chk("rand_accepted", accepted > 50, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
